// File: rtl/qspi_mux_exerciser_pkg.sv
// Shared constants and types for the QSPI mux exerciser.
// Register indices, AXI response codes and state encodings.
package qspi_mux_exerciser_pkg;

  localparam int REG_START   = 0;
  localparam int REG_ABORT   = 1;
  localparam int REG_STATUS  = 2;
  localparam int REG_TIMEOUT = 3;
  localparam int CH_BASE     = 16;
  localparam int CH_STRIDE   = 4;
  localparam int CH_VALUE    = 0;
  localparam int CH_REPEAT   = 1;
  localparam int CH_DONE     = 2;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REL
  } ch_state_t;

  typedef enum logic [1:0] {
    AX_IDLE,
    AX_EXEC,
    AX_RESP
  } ax_state_t;

endpackage

// File: rtl/qspi_mux_exerciser_if.sv
// AXI4-Lite bundle between the bus master and the exerciser.
// Signal names follow the usual S_AXI_* slave naming.
interface qspi_mux_exerciser_if #(
  parameter int AW = 8
);
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave front end: one-cycle write/read strobes to
// the register file, registered read data and responses.
module axi4_lite_slave
  import qspi_mux_exerciser_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_aresetn,
  qspi_mux_exerciser_if.slave s_axi,
  output logic [AW-1:0] o_waddr,
  output logic [31:0]   o_wdata,
  output logic          o_write,
  input  logic [1:0]    i_wresp,
  output logic [AW-1:0] o_raddr,
  output logic          o_read,
  input  logic [31:0]   i_rdata,
  input  logic [1:0]    i_rresp
);

  ax_state_t   r_ws, w_ws_nxt;
  ax_state_t   r_rs, w_rs_nxt;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic        w_aw_hs, w_ar_hs;
  logic        w_unused;

  assign w_unused = ^{s_axi.S_AXI_AWPROT,
                      s_axi.S_AXI_ARPROT,
                      s_axi.S_AXI_WSTRB};

  always_ff @(posedge clk) begin
    if (!i_aresetn) begin
      r_ws <= AX_IDLE;
      r_rs <= AX_IDLE;
    end else begin
      r_ws <= w_ws_nxt;
      r_rs <= w_rs_nxt;
    end
  end

  always_comb begin
    w_ws_nxt = r_ws;
    unique case (r_ws)
      AX_IDLE: if (w_aw_hs) w_ws_nxt = AX_EXEC;
      AX_EXEC: w_ws_nxt = AX_RESP;
      AX_RESP: if (s_axi.S_AXI_BREADY) w_ws_nxt = AX_IDLE;
      default: w_ws_nxt = AX_IDLE;
    endcase
  end

  always_comb begin
    w_rs_nxt = r_rs;
    unique case (r_rs)
      AX_IDLE: if (w_ar_hs) w_rs_nxt = AX_EXEC;
      AX_EXEC: w_rs_nxt = AX_RESP;
      AX_RESP: if (s_axi.S_AXI_RREADY) w_rs_nxt = AX_IDLE;
      default: w_rs_nxt = AX_IDLE;
    endcase
  end

  // Address and data are taken together so one strobe carries both
  assign w_aw_hs = (r_ws == AX_IDLE) && s_axi.S_AXI_AWVALID
                   && s_axi.S_AXI_WVALID;
  assign w_ar_hs = (r_rs == AX_IDLE) && s_axi.S_AXI_ARVALID;

  always_comb begin
    s_axi.S_AXI_AWREADY = w_aw_hs;
    s_axi.S_AXI_WREADY  = w_aw_hs;
    s_axi.S_AXI_BVALID  = (r_ws == AX_RESP);
    s_axi.S_AXI_BRESP   = r_bresp;
    s_axi.S_AXI_ARREADY = w_ar_hs;
    s_axi.S_AXI_RVALID  = (r_rs == AX_RESP);
    s_axi.S_AXI_RDATA   = r_rdata;
    s_axi.S_AXI_RRESP   = r_rresp;
    o_write = (r_ws == AX_EXEC);
    o_read  = (r_rs == AX_EXEC);
  end

  always_ff @(posedge clk) begin
    if (!i_aresetn) begin
      o_waddr <= '0;
      o_wdata <= '0;
      o_raddr <= '0;
      r_bresp <= OKAY;
      r_rresp <= OKAY;
      r_rdata <= '0;
    end else begin
      if (w_aw_hs) begin
        o_waddr <= s_axi.S_AXI_AWADDR;
        o_wdata <= s_axi.S_AXI_WDATA;
      end
      if (w_ar_hs) o_raddr <= s_axi.S_AXI_ARADDR;
      if (o_write) r_bresp <= i_wresp;
      if (o_read) begin
        r_rdata <= i_rdata;
        r_rresp <= i_rresp;
      end
    end
  end

endmodule

// File: rtl/qspi_mux_exerciser_channel.sv
// One requestor channel: handshake FSM, ack timer and
// completed-handshake counter.
module mux_exerciser_channel
  import qspi_mux_exerciser_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_ack,
  input  logic        i_to_clr,
  input  logic [31:0] i_repeat,
  input  logic [31:0] i_timeout,
  output logic        o_request,
  output logic        o_busy,
  output logic        o_to_flag,
  output logic [31:0] o_done
);

  ch_state_t   r_state, w_next;
  logic [31:0] r_timer, r_done, w_rep;
  logic        r_to, w_hit, w_to_evt;

  assign w_rep = (i_repeat == '0) ? 32'd1 : i_repeat;
  assign w_hit = (i_timeout != '0)
                 && (r_timer + 32'd1 == i_timeout);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_to_evt = 1'b0;
    if (i_abort) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (i_start) w_next = REQ;
        REQ: begin
          if (i_ack) begin
            w_next = REL;
          end else if (w_hit) begin
            w_next   = IDLE;
            w_to_evt = 1'b1;
          end
        end
        REL: begin
          if (!i_ack) begin
            w_next = (r_done < w_rep) ? REQ : IDLE;
          end else if (w_hit) begin
            w_next   = IDLE;
            w_to_evt = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Timer restarts on every state change, so it measures REQ/REL dwell
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
      r_done  <= '0;
      r_to    <= 1'b0;
    end else begin
      if (w_next != r_state) r_timer <= '0;
      else                   r_timer <= r_timer + 32'd1;
      if (r_state == IDLE && w_next == REQ)
        r_done <= '0;
      else if (r_state == REQ && w_next == REL)
        r_done <= r_done + 32'd1;
      if (w_to_evt)      r_to <= 1'b1;
      else if (i_to_clr) r_to <= 1'b0;
    end
  end

  always_comb begin
    o_request = (r_state == REQ);
    o_busy    = (r_state != IDLE);
    o_to_flag = r_to;
    o_done    = r_done;
  end

endmodule

// File: rtl/qspi_mux_exerciser.sv
// QSPI mux exerciser top: AXI register file and per-channel
// request/ack stimulus engines.
module qspi_mux_exerciser
  import qspi_mux_exerciser_pkg::*;
#(
  parameter int AW       = 8,
  parameter int CHANNELS = 4,
  parameter int DW       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  qspi_mux_exerciser_if.slave    s_axi,
  output logic [CHANNELS*DW-1:0] value,
  output logic [CHANNELS-1:0]    request,
  input  logic [CHANNELS-1:0]    ack
);

  localparam int IW = AW - 2;

  logic [AW-1:0]       w_waddr, w_raddr;
  logic [31:0]         w_wdata, w_rdata;
  logic                w_ashi_write, w_ashi_read;
  logic [1:0]          w_wresp, w_rresp;
  logic [IW-1:0]       w_widx, w_ridx, w_wrel, w_rrel;
  logic [IW-3:0]       w_wch, w_rch;
  logic [1:0]          w_woff, w_roff;
  logic                w_wch_ok, w_rch_ok, w_unused;
  logic [CHANNELS-1:0] w_wsel, w_rsel, w_busy, w_to;
  logic [CHANNELS-1:0] w_start, w_abort, w_to_clr;
  logic [CHANNELS-1:0] w_val_we, w_rep_we;
  logic                w_tmo_we;
  logic [31:0]         w_rval, w_rrep, w_rdone;
  logic [31:0]         w_done [CHANNELS];
  logic [DW-1:0]       r_value [CHANNELS];
  logic [31:0]         r_repeat [CHANNELS];
  logic [31:0]         r_timeout;

  axi4_lite_slave #(.AW(AW)) u_axi (
    .clk       (clk),
    .i_aresetn (~reset),
    .s_axi     (s_axi),
    .o_waddr   (w_waddr),
    .o_wdata   (w_wdata),
    .o_write   (w_ashi_write),
    .i_wresp   (w_wresp),
    .o_raddr   (w_raddr),
    .o_read    (w_ashi_read),
    .i_rdata   (w_rdata),
    .i_rresp   (w_rresp)
  );

  assign w_unused = ^{w_waddr[1:0], w_raddr[1:0]};
  assign w_widx = w_waddr[AW-1:2];
  assign w_ridx = w_raddr[AW-1:2];
  assign w_wrel = w_widx - IW'(CH_BASE);
  assign w_rrel = w_ridx - IW'(CH_BASE);
  assign w_wch  = w_wrel[IW-1:2];
  assign w_rch  = w_rrel[IW-1:2];
  assign w_woff = w_wrel[1:0];
  assign w_roff = w_rrel[1:0];

  // One-hot channel selects; out-of-range channels select nothing
  always_comb begin
    w_wsel = '0;
    w_rsel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_wsel[i] = (w_widx >= IW'(CH_BASE))
                  && (32'(w_wch) == i);
      w_rsel[i] = (w_ridx >= IW'(CH_BASE))
                  && (32'(w_rch) == i);
    end
  end

  assign w_wch_ok = |w_wsel;
  assign w_rch_ok = |w_rsel;

  always_comb begin
    w_wresp  = OKAY;
    w_start  = '0;
    w_abort  = '0;
    w_to_clr = '0;
    w_val_we = '0;
    w_rep_we = '0;
    w_tmo_we = 1'b0;
    if (w_ashi_write) begin
      unique case (1'b1)
        w_widx == IW'(REG_START):
          w_start = w_wdata[CHANNELS-1:0];
        w_widx == IW'(REG_ABORT):
          w_abort = w_wdata[CHANNELS-1:0];
        w_widx == IW'(REG_STATUS):
          w_to_clr = w_wdata[8 +: CHANNELS];
        w_widx == IW'(REG_TIMEOUT):
          w_tmo_we = 1'b1;
        w_wch_ok && w_woff == 2'(CH_VALUE):
          if (|(w_wsel & w_busy)) w_wresp = SLVERR;
          else                    w_val_we = w_wsel;
        w_wch_ok && w_woff == 2'(CH_REPEAT):
          if (|(w_wsel & w_busy)) w_wresp = SLVERR;
          else                    w_rep_we = w_wsel;
        w_wch_ok && w_woff == 2'(CH_DONE):
          w_wresp = SLVERR;
        default:
          w_wresp = DECERR;
      endcase
    end
  end

  always_comb begin
    w_rval  = '0;
    w_rrep  = '0;
    w_rdone = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_rsel[i]) begin
        w_rval  = 32'(r_value[i]);
        w_rrep  = r_repeat[i];
        w_rdone = w_done[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    w_rresp = OKAY;
    if (w_ashi_read) begin
      unique case (1'b1)
        w_ridx == IW'(REG_START):
          w_rdata[CHANNELS-1:0] = w_busy;
        w_ridx == IW'(REG_ABORT):
          w_rdata = '0;
        w_ridx == IW'(REG_STATUS): begin
          w_rdata[CHANNELS-1:0]  = w_busy;
          w_rdata[8 +: CHANNELS] = w_to;
        end
        w_ridx == IW'(REG_TIMEOUT):
          w_rdata = r_timeout;
        w_rch_ok && w_roff == 2'(CH_VALUE):
          w_rdata = w_rval;
        w_rch_ok && w_roff == 2'(CH_REPEAT):
          w_rdata = w_rrep;
        w_rch_ok && w_roff == 2'(CH_DONE):
          w_rdata = w_rdone;
        default:
          w_rresp = DECERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_value[i]  <= '0;
        r_repeat[i] <= 32'd1;
      end
    end else begin
      if (w_tmo_we) r_timeout <= w_wdata;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_val_we[i]) r_value[i]  <= w_wdata[DW-1:0];
        if (w_rep_we[i]) r_repeat[i] <= w_wdata;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign value[g*DW +: DW] = r_value[g];

    mux_exerciser_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_start[g]),
      .i_abort   (w_abort[g]),
      .i_ack     (ack[g]),
      .i_to_clr  (w_to_clr[g]),
      .i_repeat  (r_repeat[g]),
      .i_timeout (r_timeout),
      .o_request (request[g]),
      .o_busy    (w_busy[g]),
      .o_to_flag (w_to[g]),
      .o_done    (w_done[g])
    );
  end

endmodule

// File: tb/tb_qspi_mux_exerciser.sv
// Directed bench for qspi_mux_exerciser: AXI register access,
// repeated handshakes, timeout, abort, busy protection, reset.
module tb_qspi_mux_exerciser;

  localparam int CH = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qspi_mux_exerciser_if #(.AW(8)) axi ();

  logic [CH*DW-1:0] value;
  logic [CH-1:0]    request;
  logic [CH-1:0]    ack;

  qspi_mux_exerciser #(
    .AW(8), .CHANNELS(CH), .DW(DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_axi   (axi),
    .value   (value),
    .request (request),
    .ack     (ack)
  );

  // ack model: request delayed by lat[i] cycles when enabled
  logic [CH-1:0] ack_en;
  int            lat [CH];
  logic [7:0]    hist [CH];

  always @(posedge clk)
    for (int i = 0; i < CH; i++)
      hist[i] <= {hist[i][6:0], request[i]};

  always_comb begin
    ack = '0;
    for (int i = 0; i < CH; i++)
      ack[i] = ack_en[i] & hist[i][lat[i]-1];
  end

  logic          cnt_clr;
  logic [CH-1:0] req_d;
  int            hi_cnt [CH];
  int            rise_cnt [CH];
  int            val_bad;

  always @(posedge clk) begin
    req_d <= request;
    for (int i = 0; i < CH; i++) begin
      if (cnt_clr) begin
        hi_cnt[i]   <= 0;
        rise_cnt[i] <= 0;
      end else begin
        if (request[i]) hi_cnt[i] <= hi_cnt[i] + 1;
        if (request[i] && !req_d[i])
          rise_cnt[i] <= rise_cnt[i] + 1;
      end
    end
    if (cnt_clr) val_bad <= 0;
    else if (request[1] && value[DW +: DW] !== 32'hA5A5)
      val_bad <= val_bad + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic axi_wr(input logic [7:0] a,
                        input logic [31:0] d,
                        output logic [1:0] resp);
    bit hs, got;
    hs = 0; got = 0; resp = 2'bxx;
    axi.S_AXI_AWADDR  = a;
    axi.S_AXI_WDATA   = d;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (axi.S_AXI_AWREADY) begin hs = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b1;
    #1;
    for (int n = 0; n < 20 && hs; n++) begin
      if (axi.S_AXI_BVALID) begin
        resp = axi.S_AXI_BRESP; got = 1; break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;
    check("axi_wr_complete", 32'(got), 32'd1);
  endtask

  task automatic axi_rd(input logic [7:0] a,
                        output logic [31:0] d,
                        output logic [1:0] resp);
    bit hs, got;
    hs = 0; got = 0; d = 'x; resp = 2'bxx;
    axi.S_AXI_ARADDR  = a;
    axi.S_AXI_ARVALID = 1'b1;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (axi.S_AXI_ARREADY) begin hs = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b1;
    #1;
    for (int n = 0; n < 20 && hs; n++) begin
      if (axi.S_AXI_RVALID) begin
        d = axi.S_AXI_RDATA; resp = axi.S_AXI_RRESP;
        got = 1; break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b0;
    check("axi_rd_complete", 32'(got), 32'd1);
  endtask

  task automatic wr(input string tag, input logic [7:0] a,
                    input logic [31:0] d,
                    input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_wr(a, d, r);
    check(tag, 32'(r), 32'(exp_resp));
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [31:0] exp);
    logic [31:0] v;
    logic [1:0]  r;
    axi_rd(a, v, r);
    check(tag, v, exp);
    check({tag, "_resp"}, 32'(r), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [1:0]  r;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;
    ack_en  = '0;
    cnt_clr = 1'b0;
    for (int i = 0; i < CH; i++) lat[i] = 1;

    reset = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(1);

    // reset state
    check("rst_request", 32'(request), 32'd0);
    check("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    rd("rst_status", 8'd8, 32'd0);
    rd("rst_repeat0", 8'd68, 32'd1);
    rd("rst_value0", 8'd64, 32'd0);
    rd("rst_done0", 8'd72, 32'd0);
    rd("rst_timeout", 8'd12, 32'd0);
    axi_rd(8'd20, v, r);
    check("idx5_decerr", 32'(r), 32'd3);
    axi_rd(8'd76, v, r);
    check("ch_off3_decerr", 32'(r), 32'd3);
    wr("ch4_wr_decerr", 8'd128, 32'h1, 2'd3);

    // repeated handshake on channel 1
    lat[1] = 2;
    ack_en = 4'b0010;
    wr("wr_value1", 8'd80, 32'hA5A5, 2'd0);
    wr("wr_repeat1", 8'd84, 32'd3, 2'd0);
    rd("rd_value1", 8'd80, 32'hA5A5);
    clr_counts();
    wr("start1", 8'd0, 32'h2, 2'd0);
    idle(60);
    check("hs_pulses", 32'(rise_cnt[1]), 32'd3);
    check("hs_value_stable", 32'(val_bad), 32'd0);
    check("hs_value_out", value[DW +: DW], 32'hA5A5);
    rd("hs_done1", 8'd88, 32'd3);
    rd("hs_status", 8'd8, 32'd0);
    ack_en = '0;

    // timeout on channel 0
    wr("wr_timeout", 8'd12, 32'd10, 2'd0);
    clr_counts();
    wr("start0_to", 8'd0, 32'h1, 2'd0);
    idle(30);
    check("to_req_cycles", 32'(hi_cnt[0]), 32'd10);
    check("to_request", 32'(request), 32'd0);
    rd("to_status", 8'd8, 32'h100);
    wr("to_clear", 8'd8, 32'h100, 2'd0);
    rd("to_status_clr", 8'd8, 32'd0);
    wr("wr_timeout0", 8'd12, 32'd0, 2'd0);

    // busy protection and abort on channel 2
    wr("start2", 8'd0, 32'h4, 2'd0);
    check("ab_req_high", 32'(request), 32'h4);
    wr("ab_value_busy", 8'd96, 32'h1234, 2'd2);
    wr("ab_repeat_busy", 8'd100, 32'd7, 2'd2);
    rd("ab_value_kept", 8'd96, 32'd0);
    rd("ab_busy_mask", 8'd0, 32'h4);
    wr("abort2", 8'd4, 32'h4, 2'd0);
    check("ab_req_low", 32'(request), 32'd0);
    rd("ab_status", 8'd8, 32'd0);
    rd("ab_abort_rd", 8'd4, 32'd0);

    // simultaneous starts with distinct repeats/latencies
    for (int i = 0; i < CH; i++) lat[i] = i + 1;
    ack_en = '1;
    wr("sim_rep0", 8'd68, 32'd1, 2'd0);
    wr("sim_rep1", 8'd84, 32'd2, 2'd0);
    wr("sim_rep2", 8'd100, 32'd3, 2'd0);
    wr("sim_rep3", 8'd116, 32'd4, 2'd0);
    clr_counts();
    wr("sim_start", 8'd0, 32'hF, 2'd0);
    wr("sim_restart", 8'd0, 32'hE, 2'd0);
    idle(150);
    rd("sim_done0", 8'd72, 32'd1);
    rd("sim_done1", 8'd88, 32'd2);
    rd("sim_done2", 8'd104, 32'd3);
    rd("sim_done3", 8'd120, 32'd4);
    check("sim_rise1", 32'(rise_cnt[1]), 32'd2);
    check("sim_rise2", 32'(rise_cnt[2]), 32'd3);
    check("sim_rise3", 32'(rise_cnt[3]), 32'd4);
    rd("sim_busy_end", 8'd0, 32'd0);
    ack_en = '0;

    // reset in the middle of a handshake
    wr("rst_start0", 8'd0, 32'h1, 2'd0);
    check("rst_req_before", 32'(request), 32'h1);
    reset = 1'b1;
    idle(1);
    check("rst_req_after", 32'(request), 32'd0);
    reset = 1'b0;
    idle(1);
    rd("rst_status_after", 8'd8, 32'd0);
    rd("rst_repeat3_after", 8'd116, 32'd1);
    wr("rst_restart0", 8'd0, 32'h1, 2'd0);
    check("rst_req_again", 32'(request), 32'h1);
    rd("rst_busy_again", 8'd8, 32'h1);
    wr("rst_abort0", 8'd4, 32'h1, 2'd0);
    check("rst_req_final", 32'(request), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
